// File: rtl/bist_pattern_ctrl_if.sv
// Bus between the BIST sequencer and its environment: run control,
// stimulus/response to the gate-level DUT, and run status/signature.
// The master side is the environment; the slave side is the sequencer.
interface bist_pattern_ctrl_if #(
    parameter int PAT_W  = 2,
    parameter int RSP_W  = 1,
    parameter int MISR_W = 8
);
    logic              start;
    logic              abort;
    logic              mode;
    logic [MISR_W-1:0] golden_sig;
    logic [PAT_W-1:0]  pat_out;
    logic [RSP_W-1:0]  rsp_in;
    logic              busy;
    logic              done;
    logic              pass;
    logic [MISR_W-1:0] signature;
    logic [PAT_W:0]    pat_count;

    modport master (
        output start, abort, mode, golden_sig, rsp_in,
        input  pat_out, busy, done, pass, signature, pat_count
    );

    modport slave (
        input  start, abort, mode, golden_sig, rsp_in,
        output pat_out, busy, done, pass, signature, pat_count
    );
endinterface

// File: rtl/bist_pattern_ctrl.sv
// BIST pattern sequencer: applies exhaustive or LFSR stimulus to a DUT,
// waits SETTLE cycles per pattern, compacts each response into a MISR and
// compares the final signature against a golden value.
module bist_pattern_ctrl #(
    parameter int                PAT_W     = 2,
    parameter int                RSP_W     = 1,
    parameter int                MISR_W    = 8,
    parameter logic [MISR_W-1:0] MISR_POLY = 8'h1D,
    parameter logic [PAT_W-1:0]  LFSR_POLY = 2'b11,
    parameter logic [PAT_W-1:0]  SEED      = PAT_W'(1),
    parameter int                SETTLE    = 1
) (
    input  logic                clk,
    input  logic                rst,
    bist_pattern_ctrl_if.slave  bus
);
    // Settle counter only needs to hold SETTLE-1.
    localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    // Pattern totals: full counter range, or maximal LFSR (all-zero excluded).
    localparam logic [PAT_W:0] N_EXH  = (PAT_W+1)'(1) << PAT_W;
    localparam logic [PAT_W:0] N_LFSR = N_EXH - 1'b1;

    typedef enum logic [2:0] {
        S_IDLE, S_APPLY, S_SETTLE, S_CAPTURE, S_COMPARE, S_DONE
    } state_t;

    state_t            state;
    logic              mode_q;
    logic [MISR_W-1:0] golden_q;
    logic [SCW-1:0]    scnt;

    logic [MISR_W-1:0] misr_nxt;
    logic [PAT_W-1:0]  pat_nxt;
    logic              last_pat;
    logic              running;

    // Next MISR value, next stimulus pattern and end-of-run detection.
    always_comb begin
        misr_nxt = {bus.signature[MISR_W-2:0], 1'b0}
                 ^ (bus.signature[MISR_W-1] ? MISR_POLY : '0)
                 ^ MISR_W'(bus.rsp_in);
        pat_nxt  = mode_q ? ((bus.pat_out << 1) | PAT_W'(^(bus.pat_out & LFSR_POLY)))
                          : bus.pat_out + 1'b1;
        last_pat = (bus.pat_count + 1'b1) == (mode_q ? N_LFSR : N_EXH);
        running  = (state != S_IDLE) && (state != S_DONE);
    end

    // Sequencer FSM with registered outputs; abort overrides every busy transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            mode_q        <= 1'b0;
            golden_q      <= '0;
            scnt          <= '0;
            bus.pat_out   <= '0;
            bus.signature <= '0;
            bus.pat_count <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.pass      <= 1'b0;
        end else if (running && bus.abort) begin
            // Partial signature/count are kept for post-mortem inspection.
            state    <= S_IDLE;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.pass <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        mode_q        <= bus.mode;
                        golden_q      <= bus.golden_sig;
                        bus.signature <= '0;
                        bus.pat_count <= '0;
                        bus.done      <= 1'b0;
                        bus.pass      <= 1'b0;
                        bus.busy      <= 1'b1;
                        bus.pat_out   <= bus.mode ? SEED : '0;
                        state         <= S_APPLY;
                    end
                end
                S_APPLY: begin
                    if (SETTLE > 0) begin
                        scnt  <= SCW'(SETTLE - 1);
                        state <= S_SETTLE;
                    end else begin
                        state <= S_CAPTURE;
                    end
                end
                S_SETTLE: begin
                    if (scnt == '0) state <= S_CAPTURE;
                    else            scnt  <= scnt - 1'b1;
                end
                S_CAPTURE: begin
                    bus.signature <= misr_nxt;
                    bus.pat_count <= bus.pat_count + 1'b1;
                    if (last_pat) begin
                        state <= S_COMPARE;
                    end else begin
                        bus.pat_out <= pat_nxt;
                        state       <= S_APPLY;
                    end
                end
                S_COMPARE: begin
                    bus.pass <= (bus.signature == golden_q);
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    state    <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bist_pattern_ctrl.sv
// Directed bench: exhaustive loopback with SETTLE=1, LFSR loopback with
// SETTLE=0, golden mismatch, start-while-busy, abort and async reset.
module tb_bist_pattern_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    bist_pattern_ctrl_if #(.PAT_W(2), .RSP_W(1), .MISR_W(8)) if1 ();
    bist_pattern_ctrl_if #(.PAT_W(2), .RSP_W(1), .MISR_W(8)) if2 ();

    // Loopback: DUT response is the LSB of the applied pattern.
    assign if1.rsp_in = if1.pat_out[0];
    assign if2.rsp_in = if2.pat_out[0];

    bist_pattern_ctrl #(.SETTLE(1)) u_exh (.clk(clk), .rst(rst), .bus(if1.slave));
    bist_pattern_ctrl #(.SETTLE(0)) u_lfsr (.clk(clk), .rst(rst), .bus(if2.slave));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start1(input logic [7:0] golden);
        if1.golden_sig = golden;
        if1.mode       = 1'b0;
        if1.start      = 1'b1;
        tick();
        if1.start      = 1'b0;
    endtask

    logic [7:0] sig_exp [4];
    logic [1:0] lfsr_exp [3];

    initial begin
        sig_exp  = '{8'h00, 8'h01, 8'h02, 8'h05};
        lfsr_exp = '{2'd1, 2'd3, 2'd2};
        if1.start = 0; if1.abort = 0; if1.mode = 0; if1.golden_sig = 0;
        if2.start = 0; if2.abort = 0; if2.mode = 0; if2.golden_sig = 0;
        repeat (2) tick();
        chk("rst_pat", 32'(if1.pat_out), 0);
        chk("rst_busy", 32'(if1.busy), 0);
        chk("rst_done", 32'(if1.done), 0);
        chk("rst_cnt", 32'(if1.pat_count), 0);
        rst = 1'b0;
        tick();

        // Exhaustive loopback, golden matches.
        start1(8'h05);
        for (int k = 0; k < 4; k++) begin
            chk("exh_pat", 32'(if1.pat_out), 32'(k));
            tick();
            chk("exh_hold", 32'(if1.pat_out), 32'(k));
            tick();
            tick();
            chk("exh_sig", 32'(if1.signature), 32'(sig_exp[k]));
        end
        chk("exh_done12", 32'(if1.done), 0);
        chk("exh_busy12", 32'(if1.busy), 1);
        tick();
        chk("exh_done13", 32'(if1.done), 1);
        chk("exh_pass", 32'(if1.pass), 1);
        chk("exh_cnt", 32'(if1.pat_count), 4);
        chk("exh_busy13", 32'(if1.busy), 0);
        tick();
        chk("exh_hold_done", 32'(if1.done), 1);

        // Restart from DONE with wrong golden; stray start mid-run is ignored.
        start1(8'h04);
        chk("re_done_fall", 32'(if1.done), 0);
        chk("re_busy", 32'(if1.busy), 1);
        if1.start = 1'b1;
        tick();
        if1.start = 1'b0;
        repeat (10) tick();
        chk("re_pat_late", 32'(if1.pat_out), 3);
        tick();
        chk("re_done12", 32'(if1.done), 0);
        tick();
        chk("re_done13", 32'(if1.done), 1);
        chk("re_pass", 32'(if1.pass), 0);
        chk("re_sig", 32'(if1.signature), 32'h05);

        // Abort during the third pattern's settle.
        start1(8'h05);
        repeat (7) tick();
        chk("ab_cnt_pre", 32'(if1.pat_count), 2);
        chk("ab_pat_pre", 32'(if1.pat_out), 2);
        if1.abort = 1'b1;
        tick();
        if1.abort = 1'b0;
        chk("ab_busy", 32'(if1.busy), 0);
        chk("ab_done", 32'(if1.done), 0);
        chk("ab_cnt", 32'(if1.pat_count), 2);
        chk("ab_sig", 32'(if1.signature), 32'h01);
        tick();
        chk("ab_idle", 32'(if1.busy), 0);
        start1(8'h05);
        chk("rs_pat", 32'(if1.pat_out), 0);
        chk("rs_sig", 32'(if1.signature), 0);
        chk("rs_cnt", 32'(if1.pat_count), 0);
        chk("rs_busy", 32'(if1.busy), 1);

        // Asynchronous reset in the middle of a settle window.
        repeat (7) tick();
        chk("ar_pat_pre", 32'(if1.pat_out), 2);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_pat", 32'(if1.pat_out), 0);
        chk("ar_sig", 32'(if1.signature), 0);
        chk("ar_busy", 32'(if1.busy), 0);
        chk("ar_done", 32'(if1.done), 0);
        chk("ar_cnt", 32'(if1.pat_count), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // LFSR loopback with no settle cycles.
        if2.mode       = 1'b1;
        if2.golden_sig = 8'h06;
        if2.start      = 1'b1;
        tick();
        if2.start      = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("lf_pat", 32'(if2.pat_out), 32'(lfsr_exp[k]));
            tick();
            tick();
        end
        chk("lf_done6", 32'(if2.done), 0);
        tick();
        chk("lf_done7", 32'(if2.done), 1);
        chk("lf_pass", 32'(if2.pass), 1);
        chk("lf_cnt", 32'(if2.pat_count), 3);
        chk("lf_sig", 32'(if2.signature), 32'h06);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
